hazard_ctrl: RTL and testbench

Pipeline hazard and stall controller for the 5-stage MIPS32 core, sitting beside the ID stage. It detects load-use hazards against the EX stage and EX-resolved taken branches, and tracks occupancy of the shared multi-cycle multiply/divide unit. From these it drives the PC enable, the IF/ID enable/flush and the ID/EX bubble. It also keeps saturating stall and flush event counters for debug.

---
 rtl/hazard_ctrl.sv | 131 +++++++++++++
 tb/tb_hazard_ctrl.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline hazard and stall controller for the 5-stage MIPS32 core.
// It detects load-use and mult/div hazards and taken-branch flushes, and drives
// the PC / IF/ID / ID/EX controls. It also tracks occupancy of the mult/div unit
// and keeps saturating debug counters for stall cycles and flushes.
module hazard_ctrl #(
    parameter int MUL_LAT = 4,
    parameter int DIV_LAT = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        id_valid,
    input  logic [5:0]  id_opcode,
    input  logic [5:0]  id_funct,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic        ex_valid,
    input  logic        ex_mem_read,
    input  logic [4:0]  ex_rt,
    input  logic        branch_taken,
    output logic        pc_en,
    output logic        ifid_en,
    output logic        ifid_flush,
    output logic        idex_bubble,
    output logic        md_start,
    output logic        md_busy,
    output logic [15:0] stall_cycles,
    output logic [15:0] flush_count
);

    localparam logic [5:0] MUL_LAT_W = 6'(MUL_LAT);
    localparam logic [5:0] DIV_LAT_W = 6'(DIV_LAT);

    typedef enum logic {
        IDLE,
        BUSY
    } md_state_t;

    md_state_t  state_q, state_d;
    logic [5:0] md_cnt_q, md_cnt_d;

    logic is_md, is_div, is_hilo, uses_rt;
    logic load_use, md_hazard, stall, md_launch;

    // Decode the ID instruction and evaluate the hazard conditions.
    always_comb begin
        is_md     = id_valid && (id_opcode == 6'b000000) && (id_funct[5:2] == 4'b0110);
        is_div    = id_funct[1];
        is_hilo   = id_valid && (id_opcode == 6'b000000) &&
                    ((id_funct == 6'b010000) || (id_funct == 6'b010010));
        uses_rt   = (id_opcode == 6'b000000) || (id_opcode == 6'b000100) ||
                    (id_opcode == 6'b000101) || (id_opcode == 6'b101011);
        load_use  = ex_valid && ex_mem_read && (ex_rt != 5'd0) &&
                    ((ex_rt == id_rs) || (uses_rt && (ex_rt == id_rt)));
        md_hazard = md_busy && (is_md || is_hilo);
        stall     = id_valid && !branch_taken && (load_use || md_hazard);
        // Launch is kept ungated by reset so the state registers never see rst_n as data.
        md_launch = is_md && !stall && !branch_taken;
    end

    // Pipeline control outputs: reset forcing first, then flush over stall over normal flow.
    always_comb begin
        // NOTE: every output gets a default before any branch so no latch is inferred.
        pc_en       = 1'b1;
        ifid_en     = 1'b1;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        md_start    = md_launch;
        if (!rst_n) begin
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
            md_start    = 1'b0;
        end else if (branch_taken) begin
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
        end else if (stall) begin
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            idex_bubble = 1'b1;
        end
    end

    // Mult/div occupancy next-state: load latency on launch, count down to idle.
    always_comb begin
        state_d  = state_q;
        md_cnt_d = md_cnt_q;
        case (state_q)
            IDLE: begin
                if (md_launch) begin
                    md_cnt_d = is_div ? DIV_LAT_W : MUL_LAT_W;
                    state_d  = BUSY;
                end
            end
            BUSY: begin
                md_cnt_d = md_cnt_q - 6'd1;
                if (md_cnt_q == 6'd1) state_d = IDLE;
            end
            default: begin
                state_d  = IDLE;
                md_cnt_d = 6'd0;
            end
        endcase
    end

    // Mult/div state register; reset aborts any in-flight occupancy at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            md_cnt_q <= 6'd0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all flops update together.
            state_q  <= state_d;
            md_cnt_q <= md_cnt_d;
        end
    end

    assign md_busy = (state_q == BUSY);

    // Saturating debug counters for stall cycles and taken-branch flushes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cycles <= 16'd0;
            flush_count  <= 16'd0;
        end else begin
            if (stall && (stall_cycles != 16'hFFFF)) stall_cycles <= stall_cycles + 16'd1;
            if (branch_taken && (flush_count != 16'hFFFF)) flush_count <= flush_count + 16'd1;
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios plus randomized
// traffic, compared each cycle against a remaining-busy-cycles reference model.
module tb_hazard_ctrl;

    localparam int MUL_LAT = 4;
    localparam int DIV_LAT = 32;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        id_valid = 1'b0;
    logic [5:0]  id_opcode = '0;
    logic [5:0]  id_funct = '0;
    logic [4:0]  id_rs = '0;
    logic [4:0]  id_rt = '0;
    logic        ex_valid = 1'b0;
    logic        ex_mem_read = 1'b0;
    logic [4:0]  ex_rt = '0;
    logic        branch_taken = 1'b0;
    logic        pc_en, ifid_en, ifid_flush, idex_bubble, md_start, md_busy;
    logic [15:0] stall_cycles, flush_count;

    hazard_ctrl #(.MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_valid(id_valid), .id_opcode(id_opcode), .id_funct(id_funct),
        .id_rs(id_rs), .id_rt(id_rt),
        .ex_valid(ex_valid), .ex_mem_read(ex_mem_read), .ex_rt(ex_rt),
        .branch_taken(branch_taken),
        .pc_en(pc_en), .ifid_en(ifid_en), .ifid_flush(ifid_flush),
        .idex_bubble(idex_bubble), .md_start(md_start), .md_busy(md_busy),
        .stall_cycles(stall_cycles), .flush_count(flush_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input int observed, input int expected);
        n_checks++;
        if (observed == expected) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, observed, expected, $time);
    endtask

    // Reference model: number of future cycles the unit stays occupied, plus counters.
    int m_rem    = 0;
    int m_stalls = 0;
    int m_flush  = 0;
    bit e_start  = 0;
    bit e_stall  = 0;
    bit e_bt     = 0;
    int e_lat    = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_rem = 0; m_stalls = 0; m_flush = 0;
        end else begin
            if (e_start) m_rem = e_lat;
            else if (m_rem > 0) m_rem = m_rem - 1;
            if (e_stall) m_stalls = (m_stalls < 65535) ? m_stalls + 1 : 65535;
            if (e_bt)    m_flush  = (m_flush  < 65535) ? m_flush  + 1 : 65535;
        end
    end

    // Drive one cycle of inputs at the falling edge and compare every output against the model.
    task automatic step(input bit rst, input bit iv, input logic [5:0] op, input logic [5:0] fn,
                        input logic [4:0] rs, input logic [4:0] rt,
                        input bit ev, input bit emr, input logic [4:0] ert, input bit bt);
        bit busy, is_md, hilo, urt, lu, stl, start;
        int x_pc, x_en, x_fl, x_bub;
        @(negedge clk);
        rst_n = rst; id_valid = iv; id_opcode = op; id_funct = fn; id_rs = rs; id_rt = rt;
        ex_valid = ev; ex_mem_read = emr; ex_rt = ert; branch_taken = bt;
        #1;
        busy  = (m_rem > 0);
        is_md = iv && op == 6'd0 && (fn inside {6'd24, 6'd25, 6'd26, 6'd27});
        hilo  = iv && op == 6'd0 && (fn inside {6'd16, 6'd18});
        urt   = op inside {6'd0, 6'd4, 6'd5, 6'd43};
        lu    = ev && emr && ert != 0 && (ert == rs || (urt && ert == rt));
        stl   = iv && !bt && (lu || (busy && (is_md || hilo)));
        start = is_md && !stl && !bt;
        if (!rst) begin
            x_pc = 0; x_en = 0; x_fl = 1; x_bub = 1; start = 0; stl = 0;
        end else if (bt) begin
            x_pc = 1; x_en = 1; x_fl = 1; x_bub = 1;
        end else if (stl) begin
            x_pc = 0; x_en = 0; x_fl = 0; x_bub = 1;
        end else begin
            x_pc = 1; x_en = 1; x_fl = 0; x_bub = 0;
        end
        check("pc_en", pc_en, x_pc);
        check("ifid_en", ifid_en, x_en);
        check("ifid_flush", ifid_flush, x_fl);
        check("idex_bubble", idex_bubble, x_bub);
        check("md_start", md_start, start);
        check("md_busy", md_busy, busy);
        check("stall_cycles", stall_cycles, m_stalls);
        check("flush_count", flush_count, m_flush);
        e_start = start;
        e_stall = stl;
        e_bt    = rst && bt;
        e_lat   = fn[1] ? DIV_LAT : MUL_LAT;
    endtask

    task automatic nop(input int n);
        for (int i = 0; i < n; i++) step(1, 0, 6'd0, 6'd0, 5'd0, 5'd0, 0, 0, 5'd0, 0);
    endtask

    localparam logic [5:0] F_ADD = 6'h20, F_MULT = 6'h18, F_DIV = 6'h1A, F_MFHI = 6'h10, F_MFLO = 6'h12;

    int base;
    logic [5:0] ops [8];
    logic [5:0] fns [6];

    initial begin
        // Reset state with forced outputs.
        step(0, 1, 6'd0, F_ADD, 5'd1, 5'd2, 0, 0, 5'd0, 0);
        check("rst_pc_en", pc_en, 0);
        check("rst_flush", ifid_flush, 1);
        step(0, 0, 6'd0, 6'd0, 5'd0, 5'd0, 0, 0, 5'd0, 0);
        nop(2);

        // Load-use on rs.
        step(1, 1, 6'd0, F_ADD, 5'd5, 5'd1, 1, 1, 5'd5, 0);
        check("lu_pc_en", pc_en, 0);
        check("lu_bubble", idex_bubble, 1);
        step(1, 1, 6'd0, F_ADD, 5'd5, 5'd1, 0, 0, 5'd0, 0);
        check("lu_release", pc_en, 1);
        check("lu_count", stall_cycles, 1);
        // Register zero never hazards.
        step(1, 1, 6'd0, F_ADD, 5'd0, 5'd1, 1, 1, 5'd0, 0);
        check("lu_r0", pc_en, 1);

        // rt use: addi ignores rt, sw reads it.
        step(1, 1, 6'h08, 6'd0, 5'd1, 5'd7, 1, 1, 5'd7, 0);
        check("addi_rt", pc_en, 1);
        step(1, 1, 6'h2B, 6'd0, 5'd1, 5'd7, 1, 1, 5'd7, 0);
        check("sw_rt", pc_en, 0);
        nop(1);

        // MULT then MFLO: four stall cycles.
        base = stall_cycles;
        step(1, 1, 6'd0, F_MULT, 5'd1, 5'd2, 0, 0, 5'd0, 0);
        check("mult_start", md_start, 1);
        for (int i = 0; i < MUL_LAT; i++) begin
            step(1, 1, 6'd0, F_MFLO, 5'd0, 5'd0, 0, 0, 5'd0, 0);
            check("mflo_stall", pc_en, 0);
        end
        step(1, 1, 6'd0, F_MFLO, 5'd0, 5'd0, 0, 0, 5'd0, 0);
        check("mflo_go", pc_en, 1);
        check("mult_done", md_busy, 0);
        check("mult_stalls", stall_cycles - base, MUL_LAT);

        // DIV back-to-back: second DIV launches at T+33.
        step(1, 1, 6'd0, F_DIV, 5'd1, 5'd2, 0, 0, 5'd0, 0);
        for (int i = 0; i < DIV_LAT; i++) begin
            step(1, 1, 6'd0, F_DIV, 5'd3, 5'd4, 0, 0, 5'd0, 0);
            check("div2_wait", md_start, 0);
        end
        step(1, 1, 6'd0, F_DIV, 5'd3, 5'd4, 0, 0, 5'd0, 0);
        check("div2_start", md_start, 1);
        nop(DIV_LAT + 1);

        // Branch wins over load-use and a mult launch.
        base = flush_count;
        step(1, 1, 6'd0, F_MULT, 5'd6, 5'd2, 1, 1, 5'd6, 1);
        check("br_flush", ifid_flush, 1);
        check("br_bubble", idex_bubble, 1);
        check("br_pc_en", pc_en, 1);
        check("br_md_start", md_start, 0);
        nop(1);
        check("br_count", flush_count - base, 1);

        // Reset mid-DIV aborts occupancy immediately.
        step(1, 1, 6'd0, F_DIV, 5'd1, 5'd2, 0, 0, 5'd0, 0);
        nop(9);
        step(0, 0, 6'd0, 6'd0, 5'd0, 5'd0, 0, 0, 5'd0, 0);
        check("rst_busy", md_busy, 0);
        check("rst_stalls", stall_cycles, 0);
        check("rst_flushes", flush_count, 0);
        check("rst_bubble", idex_bubble, 1);
        step(1, 1, 6'd0, F_MFHI, 5'd0, 5'd0, 0, 0, 5'd0, 0);
        check("rst_mfhi", pc_en, 1);

        // Randomized traffic over a small register range to provoke hazards.
        ops = '{6'h00, 6'h00, 6'h00, 6'h04, 6'h05, 6'h2B, 6'h23, 6'h08};
        fns = '{F_ADD, F_MULT, 6'h19, F_DIV, F_MFHI, F_MFLO};
        for (int i = 0; i < 600; i++) begin
            step(1, $urandom_range(7) != 0, ops[$urandom_range(7)], fns[$urandom_range(5)],
                 5'($urandom_range(3)), 5'($urandom_range(3)),
                 $urandom_range(1), $urandom_range(1), 5'($urandom_range(3)),
                 $urandom_range(7) == 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
